// File: rtl/slow_clk_edge_monitor_if.sv
// Signal bundle between a slow-clock edge monitor and its user.
// master drives slow_in/clear and consumes the status; slave is the monitor itself.
interface slow_clk_edge_monitor_if #(
    parameter int CNT_W = 32
);
    logic             slow_in;
    logic             clear;
    logic             rise_tick;
    logic             fall_tick;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             locked;
    logic             stalled;

    modport master (
        output slow_in,
        output clear,
        input  rise_tick,
        input  fall_tick,
        input  half_period,
        input  period_valid,
        input  locked,
        input  stalled
    );

    modport slave (
        input  slow_in,
        input  clear,
        output rise_tick,
        output fall_tick,
        output half_period,
        output period_valid,
        output locked,
        output stalled
    );
endinterface

// File: rtl/slow_clk_edge_monitor.sv
// Fast-domain monitor for a slow square wave: synchronizes it, emits edge ticks, measures the
// half-period and tracks lock/stall. Define SLOW_CLK_GLITCH_FILTER_EN to reject 1-cycle glitches.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// UNLOCKED | idle after reset/clear, waiting for the first edge
// MEASURE  | measuring half-periods, counting consecutive matches
// LOCKED   | LOCK_COUNT consecutive matches seen, tick stream trusted
// STALLED  | no edge for TIMEOUT cycles, waiting for the next edge
module slow_clk_edge_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 50_000_000,
    parameter int LOCK_COUNT  = 4,
    parameter int TOL         = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    slow_clk_edge_monitor_if.slave mon
);
    localparam int                 MATCH_W      = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   TOL_V        = CNT_W'(TOL);
    localparam logic [MATCH_W-1:0] MATCH_LAST   = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MATCH_W-1:0] MATCH_FULL   = MATCH_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        MEASURE  = 2'd1,
        LOCKED   = 2'd2,
        STALLED  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_last;
    logic                   lvl;
    logic                   prev_q;
    logic                   rise;
    logic                   fall;
    logic                   edge_det;

    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       meas;
    logic [CNT_W-1:0]       diff;
    logic [CNT_W-1:0]       half_period_q;
    logic [MATCH_W-1:0]     match_q;
    logic                   have_ref_q;
    logic                   timeout_hit;
    logic                   in_tol;

    logic                   rise_tick_q;
    logic                   fall_tick_q;
    logic                   period_valid_q;

    logic                   take_meas;
    logic                   stall_enter;
    logic                   locked_o;
    logic                   stalled_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon.slow_in};
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef SLOW_CLK_GLITCH_FILTER_EN
    // prev_q already holds the filtered level, so it doubles as the filter's hold value.
    logic last_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= sync_last;
        end
    end

    assign lvl = (sync_last == last_d_q) ? sync_last : prev_q;
`else
    assign lvl = sync_last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= lvl;
        end
    end

    assign rise     = lvl & ~prev_q;
    assign fall     = ~lvl & prev_q;
    assign edge_det = rise | fall;

    // The counter restarts at the edge, so the interval is one more than its value.
    assign meas        = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    assign diff        = (meas >= half_period_q) ? (meas - half_period_q)
                                                 : (half_period_q - meas);
    assign in_tol      = (diff <= TOL_V);
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNLOCKED: begin
                if (edge_det) state_d = MEASURE;
            end
            MEASURE: begin
                if (edge_det) begin
                    if (have_ref_q && in_tol && (match_q == MATCH_LAST)) state_d = LOCKED;
                end else if (timeout_hit) begin
                    state_d = STALLED;
                end
            end
            LOCKED: begin
                if (edge_det) begin
                    if (!in_tol) state_d = MEASURE;
                end else if (timeout_hit) begin
                    state_d = STALLED;
                end
            end
            STALLED: begin
                if (edge_det) state_d = MEASURE;
            end
            default: state_d = UNLOCKED;
        endcase
        if (mon.clear) state_d = UNLOCKED;
    end

    always_comb begin
        take_meas   = 1'b0;
        stall_enter = 1'b0;
        locked_o    = 1'b0;
        stalled_o   = 1'b0;
        case (state_q)
            MEASURE, LOCKED: begin
                take_meas   = edge_det;
                stall_enter = ~edge_det & timeout_hit;
            end
            default: ;
        endcase
        locked_o  = (state_q == LOCKED);
        stalled_o = (state_q == STALLED);
        if (mon.clear) begin
            take_meas   = 1'b0;
            stall_enter = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (mon.clear || edge_det) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_period_q  <= '0;
            period_valid_q <= 1'b0;
        end else begin
            period_valid_q <= take_meas;
            if (mon.clear) begin
                half_period_q <= '0;
            end else if (take_meas) begin
                half_period_q <= meas;
            end
        end
    end

    // After a stall or restart the next measurement becomes the new reference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_ref_q <= 1'b0;
            match_q    <= '0;
        end else if (mon.clear || stall_enter) begin
            have_ref_q <= 1'b0;
            match_q    <= '0;
        end else if (take_meas) begin
            have_ref_q <= 1'b1;
            if (have_ref_q && in_tol) begin
                if (match_q != MATCH_FULL) match_q <= match_q + MATCH_W'(1);
            end else begin
                match_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_tick_q <= 1'b0;
            fall_tick_q <= 1'b0;
        end else begin
            rise_tick_q <= rise;
            fall_tick_q <= fall;
        end
    end

    assign mon.rise_tick    = rise_tick_q;
    assign mon.fall_tick    = fall_tick_q;
    assign mon.half_period  = half_period_q;
    assign mon.period_valid = period_valid_q;
    assign mon.locked       = locked_o;
    assign mon.stalled      = stalled_o;
endmodule

// File: tb/tb_slow_clk_edge_monitor.sv
// Directed bench for slow_clk_edge_monitor: table of half-period segments plus hand sequences
// for stall, clear, reset and glitch handling (also built with SLOW_CLK_GLITCH_FILTER_EN).
module tb_slow_clk_edge_monitor;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 100;
`ifdef SLOW_CLK_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int NSEG = 19;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic slow_lvl;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    slow_clk_edge_monitor_if #(.CNT_W(CNT_W)) mon ();

    slow_clk_edge_monitor #(
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .LOCK_COUNT  (4),
        .TOL         (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon)
    );

    typedef struct {
        int          len;
        logic        exp_pv;
        logic [31:0] exp_hp;
        logic        chk_lk;
        logic        exp_lk;
    } seg_t;

    seg_t tbl [NSEG];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic toggle();
        slow_lvl    = !slow_lvl;
        mon.slow_in = slow_lvl;
    endtask

    task automatic seg(input int len);
        toggle();
        repeat (len) tick();
    endtask

    initial begin
        int nr;
        int nf;

        // len = cycles until the next toggle; expectations are sampled at the tick of this toggle
        tbl[0]  = '{10,  1'b0, 32'd0,   1'b1, 1'b0};
        tbl[1]  = '{10,  1'b1, 32'd10,  1'b1, 1'b0};
        tbl[2]  = '{10,  1'b1, 32'd10,  1'b1, 1'b0};
        tbl[3]  = '{10,  1'b1, 32'd10,  1'b1, 1'b0};
        tbl[4]  = '{10,  1'b1, 32'd10,  1'b1, 1'b0};
        tbl[5]  = '{10,  1'b1, 32'd10,  1'b1, 1'b1};
        tbl[6]  = '{20,  1'b1, 32'd10,  1'b1, 1'b1};
        tbl[7]  = '{10,  1'b1, 32'd20,  1'b1, 1'b0};
        tbl[8]  = '{10,  1'b1, 32'd10,  1'b1, 1'b0};
        tbl[9]  = '{10,  1'b1, 32'd10,  1'b1, 1'b0};
        tbl[10] = '{10,  1'b1, 32'd10,  1'b1, 1'b0};
        tbl[11] = '{10,  1'b1, 32'd10,  1'b0, 1'b0};
        tbl[12] = '{12,  1'b1, 32'd10,  1'b1, 1'b1};
        tbl[13] = '{10,  1'b1, 32'd12,  1'b1, 1'b1};
        tbl[14] = '{13,  1'b1, 32'd10,  1'b1, 1'b1};
        tbl[15] = '{10,  1'b1, 32'd13,  1'b1, 1'b0};
        tbl[16] = '{100, 1'b1, 32'd10,  1'b1, 1'b0};
        tbl[17] = '{10,  1'b1, 32'd100, 1'b1, 1'b0};
        tbl[18] = '{10,  1'b1, 32'd10,  1'b1, 1'b0};

        slow_lvl    = 1'b0;
        mon.slow_in = 1'b0;
        mon.clear   = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk1("reset rise_tick", mon.rise_tick, 1'b0);
        chk1("reset fall_tick", mon.fall_tick, 1'b0);
        chk("reset half_period", mon.half_period, 32'd0);
        chk1("reset period_valid", mon.period_valid, 1'b0);
        chk1("reset locked", mon.locked, 1'b0);
        chk1("reset stalled", mon.stalled, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();

        for (int i = 0; i < NSEG; i++) begin
            toggle();
            repeat (LAT - 1) tick();
            chk($sformatf("v%0d early ticks", i), {30'd0, mon.rise_tick, mon.fall_tick}, 32'd0);
            tick();
            chk1($sformatf("v%0d rise_tick", i), mon.rise_tick, slow_lvl);
            chk1($sformatf("v%0d fall_tick", i), mon.fall_tick, !slow_lvl);
            chk1($sformatf("v%0d period_valid", i), mon.period_valid, tbl[i].exp_pv);
            chk($sformatf("v%0d half_period", i), mon.half_period, tbl[i].exp_hp);
            if (tbl[i].chk_lk) chk1($sformatf("v%0d locked", i), mon.locked, tbl[i].exp_lk);
            chk1($sformatf("v%0d stalled", i), mon.stalled, 1'b0);
            tick();
            chk($sformatf("v%0d pulse end", i),
                {29'd0, mon.rise_tick, mon.fall_tick, mon.period_valid}, 32'd0);
            repeat (tbl[i].len - LAT - 1) tick();
        end

        // relock, then hold slow_in until the timeout fires
        repeat (4) seg(10);
        chk1("relock before stall", mon.locked, 1'b1);
        toggle();
        repeat (LAT + TIMEOUT - 1) tick();
        chk1("stalled one cycle early", mon.stalled, 1'b0);
        tick();
        chk1("stalled at timeout", mon.stalled, 1'b1);
        chk1("locked in stall", mon.locked, 1'b0);
        chk("half_period held in stall", mon.half_period, 32'd10);
        toggle();
        repeat (LAT) tick();
        chk1("stall exit tick", slow_lvl ? mon.rise_tick : mon.fall_tick, 1'b1);
        chk1("stall exit stalled", mon.stalled, 1'b0);
        chk1("stall exit no period_valid", mon.period_valid, 1'b0);
        chk("stall exit half_period", mon.half_period, 32'd10);
        repeat (10 - LAT) tick();
        toggle();
        repeat (LAT) tick();
        chk1("post-stall reference pv", mon.period_valid, 1'b1);
        chk1("post-stall not locked", mon.locked, 1'b0);
        repeat (10 - LAT) tick();

        // relock, then clear coincident with a detected rise
        repeat (4) seg(10);
        chk1("relock before clear", mon.locked, 1'b1);
        if (slow_lvl) seg(10);
        toggle();
        repeat (LAT - 1) tick();
        mon.clear = 1'b1;
        tick();
        mon.clear = 1'b0;
        chk1("clear rise_tick", mon.rise_tick, 1'b1);
        chk("clear half_period", mon.half_period, 32'd0);
        chk1("clear locked", mon.locked, 1'b0);
        chk1("clear period_valid", mon.period_valid, 1'b0);
        repeat (10 - LAT) tick();
        toggle();
        repeat (LAT) tick();
        chk1("after clear first edge tick", mon.fall_tick, 1'b1);
        chk1("after clear first edge no pv", mon.period_valid, 1'b0);
        chk("after clear half_period", mon.half_period, 32'd0);
        repeat (10 - LAT) tick();
        toggle();
        repeat (LAT) tick();
        chk1("after clear second edge pv", mon.period_valid, 1'b1);
        chk("after clear second edge hp", mon.half_period, 32'd10);
        repeat (10 - LAT) tick();

        // relock, then asynchronous reset between clock edges
        repeat (4) seg(10);
        chk1("relock before reset", mon.locked, 1'b1);
        tick();
        rst = 1'b1;
        #2;
        chk1("async reset locked", mon.locked, 1'b0);
        chk("async reset half_period", mon.half_period, 32'd0);
        slow_lvl    = 1'b0;
        mon.slow_in = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        toggle();
        repeat (LAT) tick();
        chk1("post-reset rise_tick", mon.rise_tick, 1'b1);
        chk1("post-reset no pv", mon.period_valid, 1'b0);
        repeat (10 - LAT) tick();
        toggle();
        repeat (LAT) tick();
        chk1("post-reset second edge pv", mon.period_valid, 1'b1);
        chk("post-reset second edge hp", mon.half_period, 32'd10);
        repeat (10 - LAT) tick();

        // one-cycle pulse on slow_in
        nr = 0;
        nf = 0;
        mon.slow_in = 1'b1;
        tick();
        mon.slow_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            nr += int'(mon.rise_tick);
            nf += int'(mon.fall_tick);
        end
`ifdef SLOW_CLK_GLITCH_FILTER_EN
        chk("glitch rise count", nr, 32'd0);
        chk("glitch fall count", nf, 32'd0);
        mon.slow_in = 1'b1;
        repeat (LAT - 1) tick();
        chk1("5-clk pulse early rise", mon.rise_tick, 1'b0);
        tick();
        chk1("5-clk pulse rise at 4", mon.rise_tick, 1'b1);
        tick();
        mon.slow_in = 1'b0;
        repeat (LAT) tick();
        chk1("5-clk pulse fall", mon.fall_tick, 1'b1);
`else
        chk("pulse rise count", nr, 32'd1);
        chk("pulse fall count", nf, 32'd1);
`endif
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
